// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state type and schedule limits for the counter pair blocks
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TOGETHER,
        CNT1,
        DONE
    } split_state_t;

    localparam int unsigned B_LIMIT_DEF = 4;
    localparam int unsigned A_LIMIT_DEF = 9;

endpackage

// File: rtl/up_cnt4.sv
// rtl/up_cnt4.sv - 4-bit up counter with synchronous clear (priority) and enable
module up_cnt4 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= 4'd0;
        end else if (clr) begin
            q <= 4'd0;
        end else if (en) begin
            q <= q + 4'd1;
        end
    end

endmodule

// File: rtl/counter_split.sv
// rtl/counter_split.sv - replays the together/single counting schedule to recover (a, b) from a total
module counter_split
    import counter_pkg::*;
#(
    parameter int unsigned B_LIMIT = B_LIMIT_DEF,
    parameter int unsigned A_LIMIT = A_LIMIT_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load_w,
    input  logic [3:0] d,
    input  logic       out_ready,
    output logic [3:0] a_out,
    output logic [3:0] b_out,
    output logic       out_valid,
    output logic       err,
    output logic       busy
);

    localparam logic [3:0] B_LIM = B_LIMIT[3:0];
    localparam logic [3:0] A_LIM = A_LIMIT[3:0];

    split_state_t state_q;
    logic [3:0]   target_q;
    logic [3:0]   a_q;
    logic [3:0]   b_q;
    logic         out_valid_q;
    logic         err_q;
    logic         busy_q;

    logic [4:0]   sum;
    logic         hit;
    logic         over;
    logic         b_at_lim;
    logic         a_at_lim;
    logic         cnt_clr;
    logic         en_a;
    logic         en_b;

    // 5-bit sum so a+b can never wrap back below the target
    assign sum      = {1'b0, a_q} + {1'b0, b_q};
    assign hit      = (sum == {1'b0, target_q});
    assign over     = (sum > {1'b0, target_q});
    assign b_at_lim = (b_q == B_LIM);
    assign a_at_lim = (a_q == A_LIM);
    assign cnt_clr  = (state_q == IDLE) && load_w;

    always_comb begin
        en_a = 1'b0;
        en_b = 1'b0;
        case (state_q)
            TOGETHER: begin
                if (!hit && !over) begin
                    en_a = 1'b1;
                    en_b = !b_at_lim;
                end
            end
            CNT1: begin
                if (!hit && !a_at_lim && !over) begin
                    en_a = 1'b1;
                end
            end
            default: ;
        endcase
    end

    up_cnt4 u_cnt_a (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .en      (en_a),
        .q       (a_q)
    );

    up_cnt4 u_cnt_b (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .en      (en_b),
        .q       (b_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            target_q    <= 4'd0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_w) begin
                        target_q <= d;
                        busy_q   <= 1'b1;
                        state_q  <= TOGETHER;
                    end
                end
                TOGETHER: begin
                    if (hit || over) begin
                        out_valid_q <= 1'b1;
                        err_q       <= !hit;
                        state_q     <= DONE;
                    end else if (b_at_lim) begin
                        state_q <= CNT1;
                    end
                end
                CNT1: begin
                    if (hit || a_at_lim || over) begin
                        out_valid_q <= 1'b1;
                        err_q       <= !hit;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        err_q       <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule

// File: doc/counter_split.md
# counter_split

Inverse of the two-counter accumulate block. It accepts a 4-bit total (the value that block publishes as `a+b`) and reconstructs the counter pair `(a, b)` that produced it. To do this it replays the same counting schedule and stops when the running sum matches the total:
- together phase: both counters count until `b` reaches 4;
- single phase: only `a` counts, until `a` reaches 9.

It sits downstream of the accumulate block on the `q` path. It reports the recovered pair with a valid/ready handshake, or flags an error for totals the schedule can never produce.

## Interface
Parameters:
- `B_LIMIT`, 4: `b` value that ends the together phase.
- `A_LIMIT`, 9: `a` value that ends the single phase.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `load_w`  in  1  load strobe; sampled only in IDLE.
- `d`  in  4  total to decompose.
- `out_ready`  in  1  consumer accepts the result.
- `a_out`  out  4  recovered `a`; valid only while `out_valid`=1.
- `b_out`  out  4  recovered `b`; valid only while `out_valid`=1.
- `out_valid`  out  1  result (or error) available.
- `err`  out  1  total is unreachable; meaningful only while `out_valid`=1.
- `busy`  out  1  high in every state except IDLE.

## Operation
States: IDLE, TOGETHER, CNT1, DONE.
- **IDLE**
  - `load_w`=1 captures `d` into `target`, clears `a` and `b`, and moves to TOGETHER.
  - `load_w`=0: stay in IDLE.
- **TOGETHER** — evaluate in this priority order each cycle:
  1. `sum`==`target` → DONE with `err`=0.
  2. `sum`>`target` → DONE with `err`=1.
  3. `b`==`B_LIMIT` → increment `a` only; next state CNT1.
  4. Otherwise → increment both `a` and `b`.
- **CNT1**
  1. `sum`==`target` → DONE with `err`=0.
  2. `a`==`A_LIMIT` → DONE with `err`=1 (`target` is above 13).
  3. `sum`>`target` → DONE with `err`=1.
  4. Otherwise → increment `a`.
- **DONE**
  - `out_valid`=1; `a_out`/`b_out` and `err` are held stable.
  - Leave for IDLE on the cycle `out_valid`&&`out_ready`.
  - `out_ready` is ignored in every other state.
- `load_w` outside IDLE is ignored; there is no queueing.
- Arithmetic:
  - `sum` = zero-extended `a` + zero-extended `b`, 5 bits wide, so it cannot wrap.
  - `a` and `b` never exceed `A_LIMIT` and `B_LIMIT`.
- Reachable totals: 0, 2, 4, 6, 8, 9, 10, 11, 12, 13.
- Unreachable totals (set `err`): 1, 3, 5, 7, 14, 15.

## Timing
- Reset (asynchronous, `reset_n`=0) forces: state=IDLE, `a`=`b`=`target`=0, `a_out`=`b_out`=0, `out_valid`=0, `err`=0, `busy`=0.
- Reset asserted mid-operation aborts the operation immediately. Any pending result is lost.
- Edge numbering: edge 0 is the edge that samples `load_w`.
  - `busy`=1 after edge 0.
  - For a reachable total needing `n` increments, `out_valid` rises after edge `n`+1.
  - Target 0: `out_valid` after edge 1.
  - Target 8: `out_valid` after edge 5.
  - Target 13: `out_valid` after edge 10.
- Error detection timing:
  - Targets 14 and 15 reach `a`=9/`b`=4 after edge 9 and are flagged at edge 10.
  - Target 5 is flagged at edge 4 (`sum` is 6).
  - Target 7 is flagged at edge 5 (`sum` is 8).
- Handshake:
  - If `out_ready` is already high when `out_valid` rises, the result is consumed at the next edge.
  - The IDLE state reached by that handshake edge can sample a new `load_w` on the following edge.
  - `out_valid` falls after the handshake edge.
- `a_out`/`b_out` are driven directly from the registers, with no additional output register stage.

## Structure
- Shared package `counter_pkg` holds:
  - state enum `split_state_t` (IDLE, TOGETHER, CNT1, DONE);
  - constants `B_LIMIT_DEF`=4 and `A_LIMIT_DEF`=9, shared with the accumulate block.
- Sub-module `up_cnt4` is instantiated twice, once for `a` and once for `b`.
  - Ports: `clk`, `reset_n`, `clr`, `en`, `q[3:0]`.
  - Asynchronous reset; synchronous clear has priority over enable.
- Top level contains the FSM, the `target` register, the 5-bit adder/comparators, and the output logic.

## Test plan
- Reset behaviour: assert `reset_n`=0 mid-run at target 13 (during CNT1) → all outputs 0 and state IDLE immediately; `busy`=0.
- Load target 8, `out_ready`=1 → `out_valid` after edge 5 with `a_out`=4, `b_out`=4, `err`=0; then IDLE.
- Load target 13, `out_ready`=0 for 3 cycles then 1 → `a_out`=9, `b_out`=4, `err`=0; outputs held stable during the stall; `load_w` pulses during the run are ignored.
- Load targets 0, 2, and 11 back-to-back, each `load_w` issued on the first IDLE cycle after the handshake edge → results (0,0), (1,1), (7,4); latencies of 1, 2, and 8 edges respectively.
- Load targets 5, 7, 14, and 15 → `err`=1 with `out_valid` after edges 4, 5, 10, and 10 respectively.
- Load target 1 → `err`=1 at edge 2, with `a_out`=1, `b_out`=1.
